// File: rtl/stm32_bus_engine.sv
// STM32 parallel-bus command engine: byte-serial echo/param/status/TX/RX-IQ transactions plus RX frame FIFO.
// Byte k of a transaction moves at edge S+1+k; IQ_valid has no backpressure, a full FIFO drops and flags fifo_ovf.
module stm32_bus_engine #(
    parameter int SAMPLE_W   = 16,
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int NPARAM     = 10,
    parameter int NSTATUS    = 5,
    parameter logic [NPARAM*8-1:0] PARAM_RESET = '0
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        DATA_SYNC,
    input  logic [7:0]                  DATA_BUS_IN,
    output logic [7:0]                  DATA_BUS_OUT,
    output logic                        DATA_BUS_OE,
    input  logic                        IQ_valid,
    input  logic [NCH*2*SAMPLE_W-1:0]   IQ_data,
    input  logic [NSTATUS*8-1:0]        status_in,
    output logic [NPARAM*8-1:0]         params,
    output logic                        params_stb,
    output logic signed [SAMPLE_W-1:0]  TX_I,
    output logic signed [SAMPLE_W-1:0]  TX_Q,
    output logic                        tx_stb,
    output logic [6:0]                  fifo_level,
    output logic                        fifo_ovf,
    output logic                        bad_cmd,
    output logic [3:0]                  stage_debug
);
    localparam int SB    = SAMPLE_W / 8;
    localparam int FW    = NCH * 2 * SAMPLE_W;
    localparam int RIQ_N = 1 + NCH * 2 * SB;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = 16;
    localparam logic [CW-1:0] PAR_LAST  = CW'(NPARAM - 1);
    localparam logic [CW-1:0] STAT_LAST = CW'(NSTATUS - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(2 * SB - 1);
    localparam logic [CW-1:0] RIQ_LAST  = CW'(RIQ_N - 1);
    localparam logic [CW-1:0] ECHO_LAST = CW'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ECHO  = 4'd1,
        S_WPAR  = 4'd2,
        S_RSTAT = 4'd3,
        S_WTX   = 4'd4,
        S_RIQ   = 4'd5,
        S_DONE  = 4'd6
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [NPARAM*8-1:0]    par_sh, par_nxt;
    logic [2*SAMPLE_W-1:0]  tx_sh, tx_nxt;
    logic [NSTATUS*8-1:0]   stat_snap;
    logic [RIQ_N*8-1:0]     hold;
    logic [FW-1:0]          pay, rd_frame;
    logic [7:0]             echo_q, hdr;
    logic [FW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [6:0]             lvl_nxt;
    logic                   empty, full, pop_req, do_pop, push_ok, ovf_evt;
    logic                   par_commit, tx_commit, bad;

    assign stage_debug = state;

    always_comb begin
        state_nxt  = state;
        pop_req    = 1'b0;
        par_commit = 1'b0;
        tx_commit  = 1'b0;
        bad        = 1'b0;
        if (DATA_SYNC) begin
            // a new sync always wins: the running transaction is dropped uncommitted
            case (DATA_BUS_IN)
                8'd0:    state_nxt = S_ECHO;
                8'd1:    state_nxt = S_WPAR;
                8'd2:    state_nxt = S_RSTAT;
                8'd3:    state_nxt = S_WTX;
                8'd4: begin
                    state_nxt = S_RIQ;
                    pop_req   = 1'b1;
                end
                default: begin
                    state_nxt = S_IDLE;
                    bad       = 1'b1;
                end
            endcase
        end else begin
            case (state)
                S_ECHO:  if (cnt == ECHO_LAST) state_nxt = S_DONE;
                S_WPAR:  if (cnt == PAR_LAST) begin
                    state_nxt  = S_DONE;
                    par_commit = 1'b1;
                end
                S_RSTAT: if (cnt == STAT_LAST) state_nxt = S_DONE;
                S_WTX:   if (cnt == TX_LAST) begin
                    state_nxt = S_DONE;
                    tx_commit = 1'b1;
                end
                S_RIQ:   if (cnt == RIQ_LAST) state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        par_nxt = par_sh;
        par_nxt[{cnt, 3'b000} +: 8] = DATA_BUS_IN;
        // first TX byte lands in the MSB so the final vector reads {Q, I}
        tx_nxt = tx_sh;
        tx_nxt[{TX_LAST - cnt, 3'b000} +: 8] = DATA_BUS_IN;
    end

    assign empty    = (fifo_level == 7'd0);
    assign full     = (fifo_level == 7'(FIFO_DEPTH));
    assign do_pop   = pop_req & ~empty;
    assign push_ok  = IQ_valid & (~full | do_pop);
    assign ovf_evt  = IQ_valid & full & ~do_pop;
    assign lvl_nxt  = fifo_level + {6'd0, push_ok} - {6'd0, do_pop};
    assign hdr      = {fifo_ovf, empty, lvl_nxt[5:0]};
    assign rd_frame = mem[rd_ptr];

    always_comb begin
        pay = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int b = 0; b < SB; b++) begin
                pay[(c*2*SB + b)*8 +: 8]      = rd_frame[c*2*SAMPLE_W + (SB-1-b)*8 +: 8];
                pay[(c*2*SB + SB + b)*8 +: 8] = rd_frame[c*2*SAMPLE_W + SAMPLE_W + (SB-1-b)*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr] <= IQ_data;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_ovf   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= lvl_nxt;
            if (ovf_evt)      fifo_ovf <= 1'b1;
            else if (pop_req) fifo_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt          <= '0;
            par_sh       <= '0;
            tx_sh        <= '0;
            stat_snap    <= '0;
            hold         <= '0;
            echo_q       <= '0;
            params       <= PARAM_RESET;
            params_stb   <= 1'b0;
            TX_I         <= '0;
            TX_Q         <= '0;
            tx_stb       <= 1'b0;
            bad_cmd      <= 1'b0;
            DATA_BUS_OUT <= '0;
            DATA_BUS_OE  <= 1'b0;
        end else begin
            params_stb <= par_commit;
            tx_stb     <= tx_commit;
            bad_cmd    <= bad;
            if (par_commit) params <= par_nxt;
            if (tx_commit) begin
                TX_Q <= tx_nxt[2*SAMPLE_W-1:SAMPLE_W];
                TX_I <= tx_nxt[SAMPLE_W-1:0];
            end
            if (DATA_SYNC) begin
                cnt         <= '0;
                DATA_BUS_OE <= (DATA_BUS_IN == 8'd2) || (DATA_BUS_IN == 8'd4);
                if (DATA_BUS_IN == 8'd2) stat_snap <= status_in;
                if (pop_req) begin
                    hold[7:0]         <= hdr;
                    hold[RIQ_N*8-1:8] <= empty ? '0 : pay;
                end
            end else begin
                case (state)
                    S_ECHO: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            echo_q <= DATA_BUS_IN;
                        end else begin
                            DATA_BUS_OUT <= echo_q;
                            DATA_BUS_OE  <= 1'b1;
                        end
                    end
                    S_WPAR: begin
                        cnt    <= cnt + 1'b1;
                        par_sh <= par_nxt;
                    end
                    S_RSTAT: begin
                        cnt          <= cnt + 1'b1;
                        DATA_BUS_OUT <= stat_snap[{cnt, 3'b000} +: 8];
                    end
                    S_WTX: begin
                        cnt   <= cnt + 1'b1;
                        tx_sh <= tx_nxt;
                    end
                    S_RIQ: begin
                        cnt          <= cnt + 1'b1;
                        DATA_BUS_OUT <= hold[{cnt, 3'b000} +: 8];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
